// File: rtl/spi_master_tx.sv
// SPI master, mode 0 (sck idles low, data sampled on sck rise), MSB first.
// One word is sent and received for each accepted start. sck is derived from
// clk: each sck half-period lasts CLK_DIV clk cycles. All outputs are registered.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | cs high, waiting for start
// LEAD  | cs low, sck low; first mosi bit settles before the first sck rise
// HIGH  | sck high; miso was captured on the edge that entered this state
// LOW   | sck low; the next mosi bit was driven on the edge that entered this state
// TAIL  | sck low after the last sck high phase; cs still low
// GAP   | cs high again; enforces minimum deselect time before next transfer
module spi_master_tx #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              cs,
  output logic              sck,
  output logic              mosi
);

  localparam int PH_W  = $clog2(CLK_DIV + 1);
  localparam int BC_W  = $clog2(DATA_W + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);

  // Down-counters are loaded with (length - 1) and the state ends at zero.
  localparam logic [PH_W-1:0]  PH_LOAD  = PH_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(DATA_W);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_HIGH,
    ST_LOW,
    ST_TAIL,
    ST_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                cs_q, cs_d;
  logic                sck_q, sck_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // State register and all registered outputs; reset aborts any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      gap_q     <= '0;
      bit_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      gap_q     <= gap_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      cs_q      <= cs_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and output logic; each state's terminal count triggers its exit.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    gap_d     = gap_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    cs_d      = cs_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          tx_sh_d   = tx_data;
          rx_sh_d   = '0;
          mosi_d    = tx_data[DATA_W-1];
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          phase_d   = PH_LOAD;
          bit_cnt_d = '0;
          state_d   = ST_LEAD;
        end
      end

      ST_LEAD, ST_LOW: begin
        if (phase_q == '0) begin
          sck_d     = 1'b1;
          rx_sh_d   = {rx_sh_q[DATA_W-2:0], miso};
          bit_cnt_d = bit_cnt_q + 1'b1;
          phase_d   = PH_LOAD;
          state_d   = ST_HIGH;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      ST_HIGH: begin
        if (phase_q == '0) begin
          sck_d   = 1'b0;
          phase_d = PH_LOAD;
          if (bit_cnt_q < BC_LAST) begin
            // Next bit goes out on the falling sck edge so it is stable at the next rise.
            tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
            mosi_d  = tx_sh_q[DATA_W-2];
            state_d = ST_LOW;
          end else begin
            state_d = ST_TAIL;
          end
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      ST_TAIL: begin
        if (phase_q == '0) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_q == '0) begin
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign cs      = cs_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: directed words, a scoreboard of expected results
// pushed at start time, and a monitor that checks each done pulse together with
// a simple mode-0 slave model, sck rise count and cs-low length.
module tb_spi_master_tx;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] tx_data;
  logic       miso;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       cs;
  logic       sck;
  logic       mosi;

  int miso_mode;   // 0: loopback, 1: tied high, 2: tied low
  assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1);

  spi_master_tx #(.DATA_W(8), .CLK_DIV(2), .CS_GAP(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .tx_data (tx_data),
    .miso    (miso),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .cs      (cs),
    .sck     (sck),
    .mosi    (mosi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rx;     // word the master should capture
    logic [7:0] slave;  // word the slave should see on mosi
  } exp_t;

  exp_t sb[$];
  int   n_total  = 0;
  int   n_pass   = 0;
  int   n_pushed = 0;
  int   n_done   = 0;
  int   mosi_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: slave model, timing counters and scoreboard pop on done.
  int         cs_low_cnt = 0;
  int         cs_high_cnt = 100;
  int         rise_cnt = 0;
  logic [7:0] slave_sh = 8'h00;
  logic       cs_prev = 1'b1;
  logic       sck_prev = 1'b0;
  logic       mosi_prev = 1'b0;
  logic       seen_xfer = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (cs_prev && !cs) begin
      if (seen_xfer) check("cs_gap_ge3", (cs_high_cnt >= 3), 1);
      seen_xfer  = 1'b1;
      cs_low_cnt = 0;
      rise_cnt   = 0;
      slave_sh   = 8'h00;
    end
    if (!cs_prev && cs) cs_high_cnt = 0;
    if (!cs) cs_low_cnt++;
    else     cs_high_cnt++;
    if (!sck_prev && sck && !cs) begin
      rise_cnt++;
      slave_sh = {slave_sh[6:0], mosi};
    end
    if (sck && sck_prev && (mosi !== mosi_prev)) mosi_bad++;
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rx_data", rx_data, e.rx);
        check("slave_word", slave_sh, e.slave);
        check("sck_rises", rise_cnt, 8);
        check("cs_low_cycles", cs_low_cnt, 34);
        check("busy_in_done", busy, 0);
      end
    end
    cs_prev   = cs;
    sck_prev  = sck;
    mosi_prev = mosi;
  end

  // Waits for the master to be free, then starts one word; optionally records expectation.
  task automatic send(input logic [7:0] d, input logic [7:0] exp_rx, input bit push);
    exp_t e;
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    if (busy) check("send_timeout", 1, 0);
    start   = 1'b1;
    tx_data = d;
    if (push) begin
      e.rx    = exp_rx;
      e.slave = d;
      sb.push_back(e);
      n_pushed++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (sb.size() != 0 || busy); i++) @(negedge clk);
    if (sb.size() != 0 || busy) check("idle_timeout", 1, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    tx_data   = 8'h00;
    miso_mode = 0;

    // Reset state
    repeat (10) @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx_data", rx_data, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback single word
    send(8'hAA, 8'hAA, 1);
    check("busy_after_accept", busy, 1);
    wait_idle();

    // Back-to-back words, each started in the done cycle of the previous one
    send(8'hAA, 8'hAA, 1);
    send(8'h33, 8'h33, 1);
    send(8'h0F, 8'h0F, 1);
    send(8'hFF, 8'hFF, 1);
    send(8'h55, 8'h55, 1);
    wait_idle();
    repeat (3) @(negedge clk);

    // miso tied high / low
    miso_mode = 1;
    send(8'h00, 8'hFF, 1);
    wait_idle();
    repeat (3) @(negedge clk);
    miso_mode = 2;
    send(8'hC3, 8'h00, 1);
    wait_idle();
    repeat (3) @(negedge clk);
    miso_mode = 0;

    // start and tx_data change while busy: ignored
    send(8'h99, 8'h99, 1);
    repeat (4) @(negedge clk);
    start   = 1'b1;
    tx_data = 8'h11;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    check("done_count_after_ignore", n_done, n_pushed);

    // Reset after the 4th sck rise aborts the transfer
    send(8'h66, 8'h00, 0);
    for (int i = 0; i < 100 && rise_cnt != 4; i++) begin
      @(negedge clk);
      #1;
    end
    check("reached_4th_rise", rise_cnt, 4);
    rst_n = 1'b0;
    #1;
    check("abort_cs", cs, 1);
    check("abort_sck", sck, 0);
    check("abort_busy", busy, 0);
    check("abort_rx_data", rx_data, 8'h00);
    repeat (5) @(negedge clk);
    check("abort_no_done", n_done, n_pushed);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h77, 8'h77, 1);
    wait_idle();
    repeat (5) @(negedge clk);

    check("sb_empty", sb.size(), 0);
    check("done_total", n_done, n_pushed);
    check("mosi_change_while_sck_high", mosi_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
